// File: rtl/rvfi_channel_serializer.sv
// rvfi_channel_serializer
//  Serializes a multi-retire RVFI bundle (NRET channels per cycle) into a
//  single valid/ready RVFI channel, in program order, through a DEPTH-entry
//  record FIFO. Lower channel index is the older retirement.
//  Optional macro RVFI_SERIALIZER_ORDER_CHECK_EN adds a sticky order-gap
//  detector on the output side (order_err); without it order_err is tied 0.
module rvfi_channel_serializer #(
   parameter int unsigned NRET  = 2,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned ILEN  = 32,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned REC_W = 64 + ILEN + 3 + 15 + 6*XLEN + 2*(XLEN/8),
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned LVL_W = PTR_W + 1
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic [NRET-1:0]        in_valid,
   input  logic [NRET*REC_W-1:0]  in_rec,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [REC_W-1:0]       out_rec,
   output logic [LVL_W-1:0]       level,
   output logic                   order_err
);

   logic [REC_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level_q;
   logic [PTR_W-1:0] slot_off [NRET];
   logic [LVL_W-1:0] push_cnt;
   logic             push;
   logic             pop;

   // Compaction: each valid channel lands at wr_ptr + (number of older valid channels).
   always_comb begin
      push_cnt = '0;
      for (int c = 0; c < NRET; c++) begin
         slot_off[c] = push_cnt[PTR_W-1:0];
         push_cnt    = push_cnt + LVL_W'(in_valid[c]);
      end
   end

   assign in_ready  = (level_q <= LVL_W'(DEPTH - NRET));
   assign push      = in_ready && (|in_valid);
   assign out_valid = (level_q != '0);
   assign pop       = out_valid && out_ready;
   assign out_rec   = out_valid ? mem[rd_ptr] : '0;
   assign level     = level_q;

   // Pointer and occupancy registers; async flush discards in-flight entries.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level_q <= level_q + (push ? push_cnt : LVL_W'(0)) - LVL_W'(pop);
      end
   end

   // Record storage; contents are only ever observed through level, so no reset.
   always_ff @(posedge clock) begin
      for (int c = 0; c < NRET; c++) begin
         if (push && in_valid[c]) begin
            mem[wr_ptr + slot_off[c]] <= in_rec[c*REC_W +: REC_W];
         end
      end
   end

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
   logic [63:0] last_order;
   logic        seen;
   logic        err_q;

   // Sticky flag when a popped order is not the successor of the previous one.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         last_order <= '0;
         seen       <= 1'b0;
         err_q      <= 1'b0;
      end else if (pop) begin
         if (seen && (out_rec[63:0] != last_order + 64'd1)) err_q <= 1'b1;
         last_order <= out_rec[63:0];
         seen       <= 1'b1;
      end
   end

   assign order_err = err_q;

`ifdef FORMAL
   // Formal property: the producer never emits an order gap.
   always_comb begin
      assert (!err_q);
   end
`endif
`else
   assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_channel_serializer.sv
// tb_rvfi_channel_serializer
//  Scoreboard bench: accepted channel records are queued in bundle/channel
//  order and compared against every record the DUT hands out.
module tb_rvfi_channel_serializer;

   localparam int unsigned NRET  = 2;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned ILEN  = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned REC_W = 64 + ILEN + 3 + 15 + 6*XLEN + 2*(XLEN/8);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic                  clock;
   logic                  resetn;
   logic [NRET-1:0]       in_valid;
   logic [NRET*REC_W-1:0] in_rec;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [REC_W-1:0]      out_rec;
   logic [LVL_W-1:0]      level;
   logic                  order_err;

   logic [REC_W-1:0] ch_rec [NRET];
   logic [REC_W-1:0] sb_q [$];
   int tests;
   int fails;

   rvfi_channel_serializer #(
      .NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)
   ) dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_rec(in_rec),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_rec(out_rec), .level(level), .order_err(order_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_comb begin
      for (int c = 0; c < NRET; c++) in_rec[c*REC_W +: REC_W] = ch_rec[c];
   end

   function automatic logic [REC_W-1:0] make_rec(input logic [63:0] ord);
      logic [REC_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'((REC_W + 31) / 32); i++) r = (r << 32) | REC_W'($urandom);
      r[63:0] = ord;
      return r;
   endfunction

   task automatic set_bundle(input logic [NRET-1:0] v, input logic [63:0] o0, input logic [63:0] o1);
      in_valid  = v;
      ch_rec[0] = make_rec(o0);
      ch_rec[1] = make_rec(o1);
   endtask

   // One clock: record what the DUT accepts, score what it hands out.
   task automatic cycle();
      logic [REC_W-1:0] exp_rec;
      if (in_ready && (|in_valid)) begin
         for (int c = 0; c < NRET; c++) if (in_valid[c]) sb_q.push_back(ch_rec[c]);
      end
      if (out_valid && out_ready) begin
         tests++;
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_pop: got order %0d, required no output", out_rec[63:0]);
         end else begin
            exp_rec = sb_q.pop_front();
            if (out_rec !== exp_rec) begin
               fails++;
               $display("FAIL sb_rec: got order %0d rec %h, required order %0d rec %h",
                        out_rec[63:0], out_rec, exp_rec[63:0], exp_rec);
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      in_valid  = '0;
      out_ready = 1'b0;
      ch_rec[0] = '0;
      ch_rec[1] = '0;
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      sb_q.delete();
   endtask

   task automatic drain();
      in_valid  = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && out_valid; i++) cycle();
      tests++;
      if (out_valid !== 1'b0 || level !== '0 || sb_q.size() != 0) begin
         fails++;
         $display("FAIL drain: out_valid=%b level=%0d queued=%0d, required 0/0/0",
                  out_valid, level, sb_q.size());
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (level !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_rec !== '0 || order_err !== 1'b0) begin
         fails++;
         $display("FAIL reset: level=%0d out_valid=%b in_ready=%b out_rec_zero=%b order_err=%b, required 0/0/1/1/0",
                  level, out_valid, in_ready, (out_rec == '0), order_err);
      end
   endtask

   task automatic test_pair();
      set_bundle(2'b11, 64'd5, 64'd6);
      out_ready = 1'b1;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL pair_no_bypass: out_valid=%b, required 0", out_valid);
      end
      cycle();
      in_valid = '0;
      tests++;
      if (out_valid !== 1'b1 || out_rec[63:0] !== 64'd5 || level !== LVL_W'(2)) begin
         fails++;
         $display("FAIL pair_first: valid=%b order=%0d level=%0d, required 1/5/2", out_valid, out_rec[63:0], level);
      end
      cycle();
      tests++;
      if (out_valid !== 1'b1 || out_rec[63:0] !== 64'd6 || level !== LVL_W'(1)) begin
         fails++;
         $display("FAIL pair_second: valid=%b order=%0d level=%0d, required 1/6/1", out_valid, out_rec[63:0], level);
      end
      cycle();
      tests++;
      if (out_valid !== 1'b0 || out_rec !== '0) begin
         fails++;
         $display("FAIL pair_empty: valid=%b out_rec_zero=%b, required 0/1", out_valid, (out_rec == '0));
      end
      out_ready = 1'b0;
   endtask

   task automatic test_gap();
      set_bundle(2'b10, 64'd99, 64'd9);
      out_ready = 1'b0;
      cycle();
      in_valid = '0;
      tests++;
      if (level !== LVL_W'(1) || out_rec[63:0] !== 64'd9) begin
         fails++;
         $display("FAIL gap: level=%0d order=%0d, required 1/9", level, out_rec[63:0]);
      end
      drain();
   endtask

   task automatic test_full();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_bundle(2'b11, 64'(10 + 2*i), 64'(11 + 2*i));
         tests++;
         if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_ready_%0d: in_ready=%b, required 1", i, in_ready);
         end
         cycle();
         tests++;
         if (level !== LVL_W'(2*(i+1))) begin
            fails++;
            $display("FAIL full_level_%0d: level=%0d, required %0d", i, level, 2*(i+1));
         end
      end
      set_bundle(2'b11, 64'd18, 64'd19);
      cycle();
      tests++;
      if (level !== LVL_W'(8) || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL full_hold: level=%0d in_ready=%b, required 8/0", level, in_ready);
      end
      out_ready = 1'b1;
      cycle();
      tests++;
      if (level !== LVL_W'(7) || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL full_pop1: level=%0d in_ready=%b, required 7/0", level, in_ready);
      end
      cycle();
      tests++;
      if (level !== LVL_W'(6) || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL full_pop2: level=%0d in_ready=%b, required 6/1", level, in_ready);
      end
      cycle();
      tests++;
      if (level !== LVL_W'(7)) begin
         fails++;
         $display("FAIL full_accept: level=%0d, required 7", level);
      end
      drain();
   endtask

   task automatic test_push_pop();
      out_ready = 1'b0;
      set_bundle(2'b11, 64'd30, 64'd31);
      cycle();
      set_bundle(2'b01, 64'd32, 64'd0);
      cycle();
      tests++;
      if (level !== LVL_W'(3) || out_rec[63:0] !== 64'd30) begin
         fails++;
         $display("FAIL pp_setup: level=%0d order=%0d, required 3/30", level, out_rec[63:0]);
      end
      set_bundle(2'b11, 64'd33, 64'd34);
      out_ready = 1'b1;
      cycle();
      in_valid = '0;
      tests++;
      if (level !== LVL_W'(4) || out_rec[63:0] !== 64'd31) begin
         fails++;
         $display("FAIL pp_same_cycle: level=%0d order=%0d, required 4/31", level, out_rec[63:0]);
      end
      drain();
   endtask

   task automatic test_order_check();
      do_reset();
      tests++;
      if (order_err !== 1'b0) begin
         fails++;
         $display("FAIL oc_clear: order_err=%b, required 0", order_err);
      end
      set_bundle(2'b11, 64'd1, 64'd2);
      cycle();
      set_bundle(2'b01, 64'd4, 64'd0);
      cycle();
      in_valid  = '0;
      out_ready = 1'b1;
      cycle();
      cycle();
      tests++;
      if (order_err !== 1'b0) begin
         fails++;
         $display("FAIL oc_in_seq: order_err=%b, required 0", order_err);
      end
      cycle();
      tests++;
      if (order_err !== EXP_ERR) begin
         fails++;
         $display("FAIL oc_gap: order_err=%b, required %b", order_err, EXP_ERR);
      end
      repeat (3) cycle();
      tests++;
      if (order_err !== EXP_ERR) begin
         fails++;
         $display("FAIL oc_sticky: order_err=%b, required %b", order_err, EXP_ERR);
      end
      out_ready = 1'b0;
      set_bundle(2'b11, 64'd50, 64'd51);
      cycle();
      cycle();
      resetn = 1'b0;
      #2;
      sb_q.delete();
      in_valid = '0;
      tests++;
      if (level !== '0 || out_valid !== 1'b0 || out_rec !== '0 || order_err !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL oc_midreset: level=%0d out_valid=%b out_rec_zero=%b order_err=%b in_ready=%b, required 0/0/1/0/1",
                  level, out_valid, (out_rec == '0), order_err, in_ready);
      end
      @(posedge clock);
      #1;
      resetn = 1'b1;
      cycle();
      tests++;
      if (level !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL oc_after_reset: level=%0d out_valid=%b in_ready=%b, required 0/0/1", level, out_valid, in_ready);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_pair();
      test_gap();
      test_full();
      test_push_pop();
      test_order_check();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
